// File: rtl/rf_pkg.sv
// Shared types for the register-file writeback path: request payload and arbiter grant encoding.
package rf_pkg;

    localparam int ADDRESS_WIDTH = 5;
    localparam int DATA_WIDTH    = 32;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]    data;
    } wb_req_t;

    typedef enum logic {GRANT_ALU, GRANT_MEM} grant_t;

endpackage

// File: rtl/regfile_wr_arbiter_wb_queue.sv
// DEPTH-entry writeback FIFO; head visible the cycle after push, push only when !full.
// Exposes per-entry valid and rd so the parent can build its pending-write mask.
module wb_queue
    import rf_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 push,
    input  wb_req_t                              push_dat,
    input  logic                                 pop,
    output logic                                 full,
    output logic                                 empty,
    output wb_req_t                              head,
    output logic [DEPTH-1:0]                     entry_vld,
    output logic [DEPTH-1:0][ADDRESS_WIDTH-1:0]  entry_rd
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    wb_req_t [DEPTH-1:0]    mem_q, mem_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            logic [PW-1:0] offset;
            offset       = PW'(i) - rd_ptr_q;
            entry_vld[i] = CW'(offset) < count_q;
            entry_rd[i]  = mem_q[i].rd;
        end
    end

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin share of the register-file write port between ALU and load writebacks; enqueue-to-WE3 is one cycle.
// Each source sees ready = !full of its own queue, independent of a same-cycle pop; x0 writes are accepted and dropped.
module regfile_wr_arbiter
    import rf_pkg::*;
#(
    parameter int ADDRESS_WIDTH = rf_pkg::ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = rf_pkg::DATA_WIDTH,
    parameter int DEPTH         = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_valid,
    output logic                          alu_ready,
    input  logic [ADDRESS_WIDTH-1:0]      alu_rd,
    input  logic [DATA_WIDTH-1:0]         alu_data,
    input  logic                          mem_valid,
    output logic                          mem_ready,
    input  logic [ADDRESS_WIDTH-1:0]      mem_rd,
    input  logic [DATA_WIDTH-1:0]         mem_data,
    output logic [ADDRESS_WIDTH-1:0]      A3,
    output logic [DATA_WIDTH-1:0]         WD3,
    output logic                          WE3,
    output logic [2**ADDRESS_WIDTH-1:0]   pending,
    output logic                          busy
);

    logic                                alu_full, alu_empty, mem_full, mem_empty;
    logic                                alu_push, mem_push, grant_alu, grant_mem;
    wb_req_t                             alu_head, mem_head;
    logic [DEPTH-1:0]                    alu_entry_vld, mem_entry_vld;
    logic [DEPTH-1:0][ADDRESS_WIDTH-1:0] alu_entry_rd, mem_entry_rd;
    grant_t                              last_grant_q, last_grant_d;

    assign alu_ready = !alu_full;
    assign mem_ready = !mem_full;
    assign alu_push  = alu_valid && alu_ready && (alu_rd != '0);
    assign mem_push  = mem_valid && mem_ready && (mem_rd != '0);

    wb_queue #(.DEPTH(DEPTH)) u_alu_q (
        .clk       (clk),
        .rst       (rst),
        .push      (alu_push),
        .push_dat  ('{rd: alu_rd, data: alu_data}),
        .pop       (grant_alu),
        .full      (alu_full),
        .empty     (alu_empty),
        .head      (alu_head),
        .entry_vld (alu_entry_vld),
        .entry_rd  (alu_entry_rd)
    );

    wb_queue #(.DEPTH(DEPTH)) u_mem_q (
        .clk       (clk),
        .rst       (rst),
        .push      (mem_push),
        .push_dat  ('{rd: mem_rd, data: mem_data}),
        .pop       (grant_mem),
        .full      (mem_full),
        .empty     (mem_empty),
        .head      (mem_head),
        .entry_vld (mem_entry_vld),
        .entry_rd  (mem_entry_rd)
    );

    // On contention the source that did not win last time goes first.
    always_comb begin
        grant_alu    = !alu_empty && (mem_empty || last_grant_q == GRANT_MEM);
        grant_mem    = !mem_empty && (alu_empty || last_grant_q == GRANT_ALU);
        last_grant_d = last_grant_q;
        if (grant_alu) last_grant_d = GRANT_ALU;
        if (grant_mem) last_grant_d = GRANT_MEM;
    end

    always_comb begin
        WE3 = grant_alu || grant_mem;
        A3  = '0;
        WD3 = '0;
        if (grant_alu) begin
            A3  = alu_head.rd;
            WD3 = alu_head.data;
        end else if (grant_mem) begin
            A3  = mem_head.rd;
            WD3 = mem_head.data;
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (alu_entry_vld[i]) pending[alu_entry_rd[i]] = 1'b1;
            if (mem_entry_vld[i]) pending[mem_entry_rd[i]] = 1'b1;
        end
        pending[0] = 1'b0;
    end

    assign busy = !alu_empty || !mem_empty;

    always_ff @(posedge clk) begin
        if (rst) last_grant_q <= GRANT_MEM;
        else     last_grant_q <= last_grant_d;
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomized and directed bench for regfile_wr_arbiter against a queue-based reference model.
module tb_regfile_wr_arbiter;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          alu_valid = 1'b0, mem_valid = 1'b0;
    logic [AW-1:0] alu_rd = '0, mem_rd = '0;
    logic [DW-1:0] alu_data = '0, mem_data = '0;
    logic          alu_ready, mem_ready, WE3, busy;
    logic [AW-1:0] A3;
    logic [DW-1:0] WD3;
    logic [31:0]   pending;

    regfile_wr_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .A3(A3), .WD3(WD3), .WE3(WE3), .pending(pending), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    ent_t aq[$];
    ent_t mq[$];
    bit   last_was_alu = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // 0 = no write, 1 = ALU, 2 = MEM, from the model's current queue contents.
    function automatic int model_grant();
        if (aq.size() == 0 && mq.size() == 0) return 0;
        if (mq.size() == 0) return 1;
        if (aq.size() == 0) return 2;
        return last_was_alu ? 2 : 1;
    endfunction

    task automatic check_outputs();
        int            g;
        logic [31:0]   exp_pend;
        logic [AW-1:0] exp_a3;
        logic [DW-1:0] exp_wd;
        g        = model_grant();
        exp_pend = '0;
        foreach (aq[i]) exp_pend[aq[i].rd] = 1'b1;
        foreach (mq[i]) exp_pend[mq[i].rd] = 1'b1;
        exp_a3 = (g == 1) ? aq[0].rd   : (g == 2) ? mq[0].rd   : '0;
        exp_wd = (g == 1) ? aq[0].data : (g == 2) ? mq[0].data : '0;
        check_eq("we3",       WE3,       g != 0);
        check_eq("a3",        A3,        exp_a3);
        check_eq("wd3",       WD3,       exp_wd);
        check_eq("pending",   pending,   exp_pend);
        check_eq("busy",      busy,      (aq.size() + mq.size()) != 0);
        check_eq("alu_ready", alu_ready, aq.size() < DEPTH);
        check_eq("mem_ready", mem_ready, mq.size() < DEPTH);
    endtask

    task automatic model_edge();
        bit acc_a, acc_m;
        int g;
        if (rst) begin
            aq.delete();
            mq.delete();
            last_was_alu = 1'b0;
            return;
        end
        acc_a = alu_valid && aq.size() < DEPTH;
        acc_m = mem_valid && mq.size() < DEPTH;
        g     = model_grant();
        if (g == 1) begin void'(aq.pop_front()); last_was_alu = 1'b1; end
        if (g == 2) begin void'(mq.pop_front()); last_was_alu = 1'b0; end
        if (acc_a && alu_rd != 0) aq.push_back('{rd: alu_rd, data: alu_data});
        if (acc_m && mem_rd != 0) mq.push_back('{rd: mem_rd, data: mem_data});
    endtask

    // Check outputs mid-cycle, advance the model, then cross the edge.
    task automatic step();
        @(negedge clk);
        check_outputs();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
    endtask

    initial begin
        bit            alu_hold, mem_hold;
        int            prev_src;
        logic [AW-1:0] next_alu, next_mem;

        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();

        // Single ALU write.
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        step();
        idle_inputs();
        check_eq("single_pend5", pending[5], 1'b1);
        check_eq("single_we3",   WE3,        1'b1);
        check_eq("single_a3",    A3,         5'd5);
        check_eq("single_wd3",   WD3,        32'hDEADBEEF);
        step();
        check_eq("single_pend_clear", pending, 32'h0);
        check_eq("single_busy_clear", busy,    1'b0);

        // x0 write is accepted and dropped.
        alu_valid = 1'b1; alu_rd = '0; alu_data = 32'h1234;
        check_eq("x0_ready", alu_ready, 1'b1);
        step();
        idle_inputs();
        check_eq("x0_we3",  WE3,     1'b0);
        check_eq("x0_pend", pending, 32'h0);
        step();

        // Both sources every cycle: writes must alternate after the first grant.
        next_alu = 5'd1;
        next_mem = 5'd17;
        prev_src = 0;
        for (int c = 0; c < 16; c++) begin
            alu_valid = 1'b1; alu_rd = next_alu; alu_data = 32'hA000 + 32'(next_alu);
            mem_valid = 1'b1; mem_rd = next_mem; mem_data = 32'hB000 + 32'(next_mem);
            if (alu_ready) next_alu = (next_alu == 5'd15) ? 5'd1 : next_alu + 5'd1;
            if (mem_ready) next_mem = (next_mem == 5'd31) ? 5'd17 : next_mem + 5'd1;
            if (c > 0) check_eq("both_we3", WE3, 1'b1);
            if (WE3) begin
                if (prev_src != 0) check_eq("alternate", (A3 >= 5'd17) ? 2 : 1, prev_src == 1 ? 2 : 1);
                prev_src = (A3 >= 5'd17) ? 2 : 1;
            end
            step();
        end
        idle_inputs();
        for (int i = 0; i < 6; i++) step();

        // Fill both queues, then reset: nothing queued may surface.
        alu_valid = 1'b1; alu_rd = 5'd3;  alu_data = 32'h33;
        mem_valid = 1'b1; mem_rd = 5'd20; mem_data = 32'h44;
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle_inputs();
        check_eq("rst_we3",  WE3,     1'b0);
        check_eq("rst_pend", pending, 32'h0);
        check_eq("rst_busy", busy,    1'b0);
        for (int i = 0; i < 4; i++) step();

        // Random traffic, holding inputs stable while stalled.
        for (int c = 0; c < 3000; c++) begin
            alu_hold = alu_valid && !alu_ready;
            mem_hold = mem_valid && !mem_ready;
            if (!alu_hold) begin
                alu_valid = ($urandom_range(0, 3) != 0);
                alu_rd    = AW'($urandom_range(0, 31));
                alu_data  = $urandom;
            end
            if (!mem_hold) begin
                mem_valid = ($urandom_range(0, 2) != 0);
                mem_rd    = AW'($urandom_range(0, 31));
                mem_data  = $urandom;
            end
            rst = ($urandom_range(0, 99) == 0);
            step();
            rst = 1'b0;
        end
        idle_inputs();
        for (int i = 0; i < 6; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
